memory_bus_arbiter: RTL and testbench

//  Shares the single Memory port between the core bus and the Interpreter bus. Replaces the static
//  mux-selector scheme with round-robin arbitration, an optional interpreter lock, page-mode address

---
 rtl/memory_bus_arbiter.sv | 240 ++++++++++++++++++++++++
 tb/tb_memory_bus_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : memory_bus_arbiter
// Description : Shares the single Memory port between the core bus and the
//               Interpreter bus. Features: round-robin arbitration, an
//               interpreter lock, page-mode translation of core addresses,
//               a response timeout, and the end-of-program address detector.
// Revision    : 1.0 - initial release
// ============================================================================
module memory_bus_arbiter #(
   parameter int DATA_WIDTH       = 32,
   parameter int ADDR_WIDTH       = 32,
   parameter int PAGE_OFFSET_BITS = 6,
   parameter int TIMEOUT_CYCLES   = 1024
) (
   input  logic                                   clk,
   input  logic                                   reset,

   // core bus
   input  logic                                   core_read,
   input  logic                                   core_write,
   input  logic [ADDR_WIDTH-1:0]                  core_address,
   input  logic [DATA_WIDTH-1:0]                  core_write_data,
   output logic [DATA_WIDTH-1:0]                  core_read_data,
   output logic                                   core_response,

   // interpreter bus
   input  logic                                   intp_read,
   input  logic                                   intp_write,
   input  logic [ADDR_WIDTH-1:0]                  intp_address,
   input  logic [DATA_WIDTH-1:0]                  intp_write_data,
   output logic [DATA_WIDTH-1:0]                  intp_read_data,
   output logic                                   intp_response,

   // control and status
   input  logic                                   intp_lock,
   input  logic                                   bus_mode,
   input  logic [ADDR_WIDTH-PAGE_OFFSET_BITS-1:0] page_number,
   input  logic [ADDR_WIDTH-1:0]                  end_position,
   input  logic                                   clear_finish,
   output logic                                   finish_execution,
   output logic                                   timeout_error,

   // memory port
   output logic                                   mem_read,
   output logic                                   mem_write,
   output logic [ADDR_WIDTH-1:0]                  mem_address,
   output logic [DATA_WIDTH-1:0]                  mem_write_data,
   input  logic [DATA_WIDTH-1:0]                  mem_read_data,
   input  logic                                   mem_response,

   output logic                                   owner
);

   // Counter only needs to reach TIMEOUT_CYCLES-1.
   localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

   // FSM encoding
   localparam logic [1:0] c_IDLE       = 2'd0;
   localparam logic [1:0] c_GRANT_CORE = 2'd1;
   localparam logic [1:0] c_GRANT_INTP = 2'd2;

   // Owner encoding
   localparam logic c_OWNER_INTP = 1'b0;
   localparam logic c_OWNER_CORE = 1'b1;

   logic [1:0]            r_state;
   logic                  r_owner;
   logic [c_CNT_W-1:0]    r_count;
   logic                  r_mem_read;
   logic                  r_mem_write;
   logic [ADDR_WIDTH-1:0] r_mem_address;
   logic [DATA_WIDTH-1:0] r_mem_write_data;
   logic                  r_finish;
   logic                  r_timeout_error;

   logic                  w_core_req;
   logic                  w_intp_req;
   logic                  w_start;
   logic                  w_pick_core;
   logic                  w_in_grant;
   logic                  w_last_cycle;
   logic                  w_done;
   logic                  w_timeout;
   logic                  w_end_hit;
   logic [ADDR_WIDTH-1:0] w_core_xlat_addr;

   // ------------------------------------------------------------------------
   // Request qualification and arbitration decision
   // ------------------------------------------------------------------------
   // The lock only masks the core's eligibility; an in-flight core grant is
   // never affected because arbitration happens in IDLE only.
   assign w_core_req  = (core_read | core_write) & ~intp_lock;
   assign w_intp_req  = intp_read | intp_write;
   assign w_start     = w_core_req | w_intp_req;

   // On a tie the requester that is not the last owner wins.
   assign w_pick_core = (w_core_req & w_intp_req) ? (r_owner == c_OWNER_INTP)
                                                  : w_core_req;

   // Page mode replaces everything above the page offset with page_number.
   assign w_core_xlat_addr = bus_mode ? {page_number, core_address[PAGE_OFFSET_BITS-1:0]}
                                      : core_address;

   // ------------------------------------------------------------------------
   // Completion conditions
   // ------------------------------------------------------------------------
   assign w_in_grant   = (r_state == c_GRANT_CORE) | (r_state == c_GRANT_INTP);
   assign w_last_cycle = (r_count == c_CNT_LAST);
   assign w_done       = w_in_grant & (mem_response | w_last_cycle);
   // A response arriving on the final cycle still counts as a normal completion.
   assign w_timeout    = w_in_grant & w_last_cycle & ~mem_response;

   // End-of-program detection looks at the core bus regardless of the grant.
   assign w_end_hit = (core_read | core_write) &
                      (bus_mode ? (core_address[PAGE_OFFSET_BITS-1:0] ==
                                   end_position[PAGE_OFFSET_BITS-1:0])
                                : (core_address == end_position));

   // Main state machine: IDLE arbitrates, GRANT_x waits for completion.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= c_IDLE;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (w_start) begin
                  r_state <= w_pick_core ? c_GRANT_CORE : c_GRANT_INTP;
               end
            end
            c_GRANT_CORE,
            c_GRANT_INTP: begin
               if (w_done) begin
                  r_state <= c_IDLE;
               end
            end
            default: begin
               r_state <= c_IDLE;
            end
         endcase
      end
   end

   // Owner remembers the most recent grant for round-robin tie breaking.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_owner <= c_OWNER_INTP;
      end else if ((r_state == c_IDLE) && w_start) begin
         r_owner <= w_pick_core ? c_OWNER_CORE : c_OWNER_INTP;
      end
   end

   // Timeout counter: counts grant cycles, cleared in IDLE and on completion.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (!w_in_grant || w_done) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + c_CNT_ONE;
      end
   end

   // Memory request registers: loaded from the winner, held through the grant.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mem_read       <= 1'b0;
         r_mem_write      <= 1'b0;
         r_mem_address    <= '0;
         r_mem_write_data <= '0;
      end else if ((r_state == c_IDLE) && w_start) begin
         // Read and write together are treated as a write.
         if (w_pick_core) begin
            r_mem_read       <= core_read & ~core_write;
            r_mem_write      <= core_write;
            r_mem_address    <= w_core_xlat_addr;
            r_mem_write_data <= core_write_data;
         end else begin
            r_mem_read       <= intp_read & ~intp_write;
            r_mem_write      <= intp_write;
            r_mem_address    <= intp_address;
            r_mem_write_data <= intp_write_data;
         end
      end else if (w_done) begin
         r_mem_read  <= 1'b0;
         r_mem_write <= 1'b0;
      end
   end

   // Sticky status flags; clear_finish wins over a coincident set.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_finish        <= 1'b0;
         r_timeout_error <= 1'b0;
      end else if (clear_finish) begin
         r_finish        <= 1'b0;
         r_timeout_error <= 1'b0;
      end else begin
         if (w_end_hit) begin
            r_finish <= 1'b1;
         end
         if (w_timeout) begin
            r_timeout_error <= 1'b1;
         end
      end
   end

   // Completion routing: same-cycle response and data to the current owner only.
   always_comb begin
      core_response  = 1'b0;
      intp_response  = 1'b0;
      core_read_data = '0;
      intp_read_data = '0;
      if (w_done) begin
         if (r_state == c_GRANT_CORE) begin
            core_response = 1'b1;
            if (mem_response) begin
               core_read_data = mem_read_data;
            end
         end else begin
            intp_response = 1'b1;
            if (mem_response) begin
               intp_read_data = mem_read_data;
            end
         end
      end
   end

   assign mem_read         = r_mem_read;
   assign mem_write        = r_mem_write;
   assign mem_address      = r_mem_address;
   assign mem_write_data   = r_mem_write_data;
   assign owner            = r_owner;
   assign finish_execution = r_finish;
   assign timeout_error    = r_timeout_error;

endmodule
`default_nettype wire

// File: tb/tb_memory_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_bus_arbiter
// Description : Self-checking bench for memory_bus_arbiter. A transaction-
//               level model predicts every output each cycle; directed
//               scenarios pin the model with literal expectations, then a
//               randomized phase exercises arbitration, lock, translation,
//               timeouts and the end-address detector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_bus_arbiter;

   localparam int DW  = 32;
   localparam int AW  = 32;
   localparam int OFF = 6;
   localparam int TO  = 8;
   localparam int PW  = AW - OFF;

   logic          clk = 1'b0;
   logic          reset;
   logic          core_read, core_write;
   logic [AW-1:0] core_address;
   logic [DW-1:0] core_write_data;
   logic [DW-1:0] core_read_data;
   logic          core_response;
   logic          intp_read, intp_write;
   logic [AW-1:0] intp_address;
   logic [DW-1:0] intp_write_data;
   logic [DW-1:0] intp_read_data;
   logic          intp_response;
   logic          intp_lock, bus_mode, clear_finish;
   logic [PW-1:0] page_number;
   logic [AW-1:0] end_position;
   logic          finish_execution, timeout_error;
   logic          mem_read, mem_write;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_write_data;
   logic [DW-1:0] mem_read_data;
   logic          mem_response;
   logic          owner;

   memory_bus_arbiter #(
      .DATA_WIDTH       (DW),
      .ADDR_WIDTH       (AW),
      .PAGE_OFFSET_BITS (OFF),
      .TIMEOUT_CYCLES   (TO)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .core_read        (core_read),
      .core_write       (core_write),
      .core_address     (core_address),
      .core_write_data  (core_write_data),
      .core_read_data   (core_read_data),
      .core_response    (core_response),
      .intp_read        (intp_read),
      .intp_write       (intp_write),
      .intp_address     (intp_address),
      .intp_write_data  (intp_write_data),
      .intp_read_data   (intp_read_data),
      .intp_response    (intp_response),
      .intp_lock        (intp_lock),
      .bus_mode         (bus_mode),
      .page_number      (page_number),
      .end_position     (end_position),
      .clear_finish     (clear_finish),
      .finish_execution (finish_execution),
      .timeout_error    (timeout_error),
      .mem_read         (mem_read),
      .mem_write        (mem_write),
      .mem_address      (mem_address),
      .mem_write_data   (mem_write_data),
      .mem_read_data    (mem_read_data),
      .mem_response     (mem_response),
      .owner            (owner)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // ------------------------------------------------------------------------
   // Transaction-level reference model
   // ------------------------------------------------------------------------
   logic          m_busy, m_who, m_write, m_owner, m_finish, m_terr;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata;
   int            m_age;
   logic          ev_core, ev_intp;

   initial begin
      logic exp_resp, hit, creq, ireq, win;
      logic [DW-1:0] exp_data;
      m_busy = 0; m_who = 0; m_write = 0; m_owner = 0; m_finish = 0; m_terr = 0;
      m_addr = '0; m_wdata = '0; m_age = 0; ev_core = 0; ev_intp = 0;
      forever begin
         @(negedge clk); #2;
         if (!reset) begin
            m_busy = 0; m_owner = 0; m_finish = 0; m_terr = 0; m_age = 0;
            ev_core = 0; ev_intp = 0;
            chk("rst_core_resp", core_response, 0);
            chk("rst_intp_resp", intp_response, 0);
            chk("rst_mem_rw", {mem_read, mem_write}, 0);
            chk("rst_mem_addr", mem_address, 0);
            chk("rst_mem_wdata", mem_write_data, 0);
            chk("rst_owner", owner, 0);
            chk("rst_flags", {finish_execution, timeout_error}, 0);
            chk("rst_rdata", {core_read_data, intp_read_data}, 0);
         end else begin
            exp_resp = m_busy && (mem_response || (m_age == TO - 1));
            exp_data = mem_response ? mem_read_data : '0;
            chk("mem_read", mem_read, m_busy && !m_write);
            chk("mem_write", mem_write, m_busy && m_write);
            if (m_busy) begin
               chk("mem_address", mem_address, m_addr);
               if (m_write) chk("mem_write_data", mem_write_data, m_wdata);
            end
            chk("core_response", core_response, exp_resp && m_who);
            chk("intp_response", intp_response, exp_resp && !m_who);
            if (exp_resp && m_who) chk("core_read_data", core_read_data, exp_data);
            else if (!m_owner)     chk("core_read_data_nonowner", core_read_data, 0);
            if (exp_resp && !m_who) chk("intp_read_data", intp_read_data, exp_data);
            else if (m_owner)       chk("intp_read_data_nonowner", intp_read_data, 0);
            chk("owner", owner, m_owner);
            chk("finish_execution", finish_execution, m_finish);
            chk("timeout_error", timeout_error, m_terr);

            // next-state prediction for the coming clock edge
            hit = (core_read || core_write) &&
                  (bus_mode ? (core_address[OFF-1:0] == end_position[OFF-1:0])
                            : (core_address == end_position));
            ev_core = exp_resp && m_who;
            ev_intp = exp_resp && !m_who;
            if (clear_finish) begin
               m_finish = 0; m_terr = 0;
            end else begin
               if (hit) m_finish = 1;
               if (exp_resp && !mem_response) m_terr = 1;
            end
            if (m_busy) begin
               if (exp_resp) m_busy = 0;
               else m_age++;
            end else begin
               creq = (core_read || core_write) && !intp_lock;
               ireq = intp_read || intp_write;
               if (creq || ireq) begin
                  win = (creq && ireq) ? !m_owner : creq;
                  m_owner = win; m_who = win; m_busy = 1; m_age = 0;
                  if (win) begin
                     m_write = core_write;
                     m_addr  = bus_mode ? {page_number, core_address[OFF-1:0]} : core_address;
                     m_wdata = core_write_data;
                  end else begin
                     m_write = intp_write;
                     m_addr  = intp_address;
                     m_wdata = intp_write_data;
                  end
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Memory responder: replies after mem_lat grant cycles, optional strays
   // ------------------------------------------------------------------------
   int   lat_force = 0;
   logic stray_en = 0, stray_force = 0;
   int   mem_wait, mem_lat;

   initial begin
      mem_response = 0; mem_read_data = '0; mem_wait = 0; mem_lat = 1;
      forever begin
         @(negedge clk); #1;
         if (mem_read || mem_write) begin
            mem_wait++;
            mem_response = (mem_wait == mem_lat);
         end else begin
            mem_wait = 0;
            mem_lat = (lat_force != 0) ? lat_force : int'($urandom_range(1, 10));
            mem_response = stray_force || (stray_en && ($urandom_range(0, 7) == 0));
         end
         mem_read_data = $urandom;
      end
   end

   task automatic new_core();
      int r;
      core_read  = 1'($urandom_range(0, 1));
      core_write = 1'($urandom_range(0, 1));
      if (!core_read && !core_write) core_read = 1'b1;
      core_write_data = $urandom;
      r = $urandom_range(0, 3);
      if (r == 0)      core_address = end_position;
      else if (r == 1) core_address = {AW'($urandom) >> OFF, end_position[OFF-1:0]} ;
      else             core_address = $urandom;
   endtask

   task automatic new_intp();
      intp_read  = 1'($urandom_range(0, 1));
      intp_write = 1'($urandom_range(0, 1));
      if (!intp_read && !intp_write) intp_read = 1'b1;
      intp_write_data = $urandom;
      intp_address    = $urandom;
   endtask

   // ------------------------------------------------------------------------
   // Stimulus: directed scenarios, then randomized traffic
   // ------------------------------------------------------------------------
   initial begin
      int   cnt_mw, cnt_ir, cnt_cr, ncore, nintp, gcnt;
      logic seen;
      logic order[$];
      logic [7:0] exp_seq;

      reset = 0;
      core_read = 0; core_write = 0; core_address = '0; core_write_data = '0;
      intp_read = 0; intp_write = 0; intp_address = '0; intp_write_data = '0;
      intp_lock = 0; bus_mode = 0; page_number = '0; end_position = '0; clear_finish = 0;

      repeat (3) @(negedge clk);
      #3;
      chk("t0_owner_reset", owner, 0);
      chk("t0_mem_rw_reset", {mem_read, mem_write}, 0);
      @(negedge clk); reset = 1;

      // 1: interpreter write, memory answers in the 3rd grant cycle
      lat_force = 3;
      @(negedge clk);
      intp_write = 1; intp_address = 32'h10; intp_write_data = 32'hDEADBEEF;
      cnt_mw = 0; cnt_ir = 0; cnt_cr = 0;
      for (int i = 0; i < 8; i++) begin
         #3;
         cnt_mw += int'(mem_write); cnt_ir += int'(intp_response); cnt_cr += int'(core_response);
         if (i == 1) begin
            chk("t1_mem_address", mem_address, 32'h10);
            chk("t1_mem_wdata", mem_write_data, 32'hDEADBEEF);
         end
         @(negedge clk);
         if (ev_intp) intp_write = 0;
      end
      chk("t1_mem_write_cycles", cnt_mw, 3);
      chk("t1_intp_resp_count", cnt_ir, 1);
      chk("t1_core_resp_count", cnt_cr, 0);

      // 2: both read together, four transactions each, strict alternation
      lat_force = 2;
      core_read = 1; intp_read = 1; core_address = 32'h100; intp_address = 32'h200;
      ncore = 0; nintp = 0;
      for (int i = 0; i < 200 && (core_read || intp_read); i++) begin
         #3;
         if (core_response) order.push_back(1'b1);
         if (intp_response) order.push_back(1'b0);
         @(negedge clk);
         if (ev_core) begin ncore++; if (ncore == 4) core_read = 0; end
         if (ev_intp) begin nintp++; if (nintp == 4) intp_read = 0; end
      end
      core_read = 0; intp_read = 0;
      chk("t2_resp_total", order.size(), 8);
      exp_seq = 8'b0101_0101;
      for (int i = 0; i < 8; i++) begin
         if (i < order.size()) chk($sformatf("t2_order_%0d", i), order[i], exp_seq[i]);
      end

      // 3: page-mode translation of a core read
      @(negedge clk);
      bus_mode = 1; page_number = PW'(2); core_read = 1; core_address = 32'h0000_01C5;
      #3;
      @(negedge clk); #3;
      chk("t3_xlat_addr", mem_address, 32'h0000_0085);
      chk("t3_mem_read", mem_read, 1);
      @(negedge clk); #3;
      chk("t3_core_resp", core_response, 1);
      chk("t3_core_rdata", core_read_data, mem_read_data);
      @(negedge clk);
      core_read = 0; bus_mode = 0;

      // 4: interpreter lock blocks the core until released
      @(negedge clk);
      intp_lock = 1; core_read = 1; core_address = 32'h500; intp_read = 1; intp_address = 32'h600;
      nintp = 0; cnt_cr = 0;
      for (int i = 0; i < 60 && intp_read; i++) begin
         #3;
         cnt_cr += int'(core_response);
         @(negedge clk);
         if (ev_intp) begin
            nintp++;
            if (nintp == 2) begin intp_read = 0; intp_lock = 0; end
         end
      end
      chk("t4_core_blocked", cnt_cr, 0);
      chk("t4_intp_served", nintp, 2);
      #3;
      chk("t4_owner_before_core", owner, 0);
      @(negedge clk); #3;
      chk("t4_core_owner", owner, 1);
      chk("t4_core_addr", mem_address, 32'h500);
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk); #3;
         if (core_response) seen = 1;
      end
      chk("t4_core_served", seen, 1);
      @(negedge clk); core_read = 0;

      // 5: timeout after TO grant cycles, then a stray response in IDLE
      lat_force = 100;
      @(negedge clk);
      intp_read = 1; intp_address = 32'h300;
      #3;
      chk("t5_terr_before", timeout_error, 0);
      gcnt = 0; seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         if (mem_read) gcnt++;
         if (intp_response) begin
            seen = 1;
            chk("t5_resp_grant_cycle", gcnt, 8);
            chk("t5_resp_data", intp_read_data, 0);
         end
         if (!seen) begin @(negedge clk); #3; end
      end
      chk("t5_timeout_seen", seen, 1);
      @(negedge clk);
      intp_read = 0; stray_force = 1; lat_force = 2;
      #3;
      chk("t5_terr_set", timeout_error, 1);
      chk("t5_stray_ignored", {core_response, intp_response}, 0);
      @(negedge clk);
      stray_force = 0;
      #3;
      chk("t5_no_grant_after_stray", {mem_read, mem_write}, 0);

      // 6: end-address detection, clear priority, asynchronous reset mid-grant
      @(negedge clk);
      end_position = 32'h40; core_read = 1; core_address = 32'h40;
      #3; chk("t6_finish_before", finish_execution, 0);
      @(negedge clk); #3; chk("t6_finish_set", finish_execution, 1);
      @(negedge clk); #3; chk("t6_core_resp", core_response, 1);
      @(negedge clk); core_read = 0; clear_finish = 1;
      #3; chk("t6_finish_held", finish_execution, 1);
      @(negedge clk); clear_finish = 0;
      #3;
      chk("t6_finish_cleared", finish_execution, 0);
      chk("t6_terr_cleared", timeout_error, 0);
      @(negedge clk); core_read = 1; core_address = 32'h40; clear_finish = 1;
      #3;
      @(negedge clk); clear_finish = 0;
      #3; chk("t6_clear_wins", finish_execution, 0);
      @(negedge clk); #3;
      chk("t6_finish_reset_again", finish_execution, 1);
      chk("t6_resp_before_reset", core_response, 1);
      reset = 0;
      #1;
      chk("t6_rst_resp", {core_response, intp_response}, 0);
      chk("t6_rst_mem", {mem_read, mem_write}, 0);
      chk("t6_rst_addr", mem_address, 0);
      chk("t6_rst_owner", owner, 0);
      chk("t6_rst_finish", finish_execution, 0);
      chk("t6_rst_rdata", core_read_data, 0);
      @(negedge clk); core_read = 0;
      @(negedge clk); reset = 1;

      // randomized traffic
      lat_force = 0; stray_en = 1; end_position = $urandom;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (core_read || core_write) begin
            if (ev_core) begin
               if ($urandom_range(0, 2) == 0) new_core();
               else begin core_read = 0; core_write = 0; end
            end
         end else if ($urandom_range(0, 3) == 0) new_core();
         if (intp_read || intp_write) begin
            if (ev_intp) begin
               if ($urandom_range(0, 2) == 0) new_intp();
               else begin intp_read = 0; intp_write = 0; end
            end
         end else if ($urandom_range(0, 3) == 0) new_intp();
         if ($urandom_range(0, 19) == 0) intp_lock = ~intp_lock;
         if ($urandom_range(0, 9) == 0)  bus_mode = ~bus_mode;
         if ($urandom_range(0, 9) == 0)  page_number = PW'($urandom);
         if ($urandom_range(0, 49) == 0) end_position = $urandom;
         clear_finish = ($urandom_range(0, 15) == 0);
      end

      @(negedge clk);
      #3;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
